lfsr_gen: RTL and testbench

Parametrised successor to the team's fixed 8-bit LFSR. It has:
- runtime-programmable tap mask and parallel seed load;
- the legacy serial load path;
- W output bits per cycle behind a valid/ready handshake;
- all-zero lockup recovery and on-line period measurement.

It sits between the pseudo-random stimulus consumers (scramblers, BIST pattern sources) and the control registers that program it.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_step_w.sv | 31 +++
 rtl/lfsr_gen.sv | 108 ++++++++++
 tb/tb_lfsr_gen.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the feedback function used by the step logic.
// Next state of one step is {state[N-2:0], lfsr_feedback(state, taps)}.
package lfsr_pkg;

    localparam int LFSR_MAX_N = 64;

    // Maximal-length tap masks for the shift-left / feedback-into-bit-0 form.
    localparam logic [3:0]  TAPS_4  = 4'h9;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    typedef logic [LFSR_MAX_N-1:0] lfsr_word_t;

    // Callers zero-extend narrower state/taps, so the unused upper bits drop out.
    function automatic logic lfsr_feedback(input lfsr_word_t state, input lfsr_word_t taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_step_w.sv
// Combinational W-step unroll of the LFSR: next state after W steps and the
// W output bits, first-generated bit in the MSB of word.
module lfsr_step_w
    import lfsr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic [N-1:0] state,
    input  logic [N-1:0] taps,
    output logic [N-1:0] next_state,
    output logic [W-1:0] word
);

    for (genvar g = 0; g < W; g++) begin : g_step
        logic [N-1:0] cur;
        logic [N-1:0] nxt;

        if (g == 0) begin : g_first
            assign cur = state;
        end else begin : g_rest
            assign cur = g_step[g-1].nxt;
        end

        assign word[W-1-g] = cur[N-1];
        assign nxt = {cur[N-2:0], lfsr_feedback(lfsr_word_t'(cur), lfsr_word_t'(taps))};
    end

    assign next_state = g_step[W-1].nxt;

endmodule

// File: rtl/lfsr_gen.sv
// Programmable-tap LFSR producing W bits per accepted word, with legacy serial
// load, all-zero lockup recovery and on-line period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int           N            = 8,
    parameter int           W            = 1,
    parameter logic [N-1:0] DEFAULT_TAPS = TAPS_8,
    parameter logic [N-1:0] SEED         = 8'h01
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic         s_reg_in,
    input  logic         seed_load,
    input  logic [N-1:0] seed_in,
    input  logic         tap_load,
    input  logic [N-1:0] tap_in,
    input  logic         out_ready,
    output logic [N-1:0] s_reg,
    output logic [N-1:0] taps,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         lockup,
    output logic [N-1:0] period,
    output logic         period_valid
);

    logic [N-1:0] step_next;
    logic [W-1:0] step_word;
    logic [N-1:0] state_d;
    logic [N-1:0] start_q;
    logic [N-1:0] count_q;
    logic [N-1:0] count_inc;
    logic         state_zero;
    logic         advance;
    logic         recover;
    logic         state_write;

    lfsr_step_w #(.N(N), .W(W)) u_step (
        .state      (s_reg),
        .taps       (taps),
        .next_state (step_next),
        .word       (step_word)
    );

    // Handshake: a word transfers on any edge where out_valid && out_ready.
    // out_data may be replaced only when the slot is empty or being drained.
    assign state_zero  = (s_reg == '0);
    assign advance     = enable && !load && !seed_load && (!out_valid || out_ready) && !state_zero;
    assign recover     = enable && !load && !seed_load && state_zero;
    assign state_write = seed_load || load || recover;
    assign count_inc   = (&count_q) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d = s_reg;
        if (seed_load)    state_d = seed_in;
        else if (load)    state_d = {s_reg[N-2:0], s_reg_in};
        else if (advance) state_d = step_next;
        else if (recover) state_d = SEED;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_reg        <= SEED;
            taps         <= DEFAULT_TAPS;
            out_data     <= '0;
            out_valid    <= 1'b0;
            lockup       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            start_q      <= SEED;
            count_q      <= '0;
        end else begin
            s_reg        <= state_d;
            lockup       <= recover;
            period_valid <= 1'b0;

            if (tap_load) taps <= tap_in;

            if (advance) begin
                out_data  <= step_word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A new tap mask restarts measurement from the pre-edge state.
            if (state_write) begin
                start_q <= state_d;
                count_q <= '0;
            end else if (tap_load) begin
                start_q <= s_reg;
                count_q <= '0;
            end else if (advance) begin
                if (step_next == start_q) begin
                    period       <= count_inc;
                    period_valid <= 1'b1;
                    count_q      <= '0;
                end else begin
                    count_q <= count_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three instances (N=4/W=1, N=4/W=2, N=8/W=3) share
// control inputs; per-instance scoreboards check every consumed word.
module tb_lfsr_gen;

    logic       clk;
    logic       reset;
    logic       en4, en8;
    logic       load, s_reg_in, seed_load, tap_load, out_ready;
    logic [3:0] seed_in4, tap_in4;
    logic [7:0] seed_in8, tap_in8;

    logic [3:0] a_s_reg, a_taps, a_period;
    logic [0:0] a_data;
    logic       a_valid, a_lockup, a_pv;
    logic [3:0] b_s_reg, b_taps, b_period;
    logic [1:0] b_data;
    logic       b_valid, b_lockup, b_pv;
    logic [7:0] c_s_reg, c_taps, c_period;
    logic [2:0] c_data;
    logic       c_valid, c_lockup, c_pv;

    logic [0:0] exp_a_q[$];
    logic [1:0] exp_b_q[$];
    logic [2:0] exp_c_q[$];
    logic       mon_c;
    int         checks;
    int         errors;

    lfsr_gen #(.N(4), .W(1), .DEFAULT_TAPS(4'h9), .SEED(4'h1)) dut_a (
        .clk(clk), .reset(reset), .enable(en4), .load(load), .s_reg_in(s_reg_in),
        .seed_load(seed_load), .seed_in(seed_in4), .tap_load(tap_load), .tap_in(tap_in4),
        .out_ready(out_ready), .s_reg(a_s_reg), .taps(a_taps), .out_data(a_data),
        .out_valid(a_valid), .lockup(a_lockup), .period(a_period), .period_valid(a_pv)
    );

    lfsr_gen #(.N(4), .W(2), .DEFAULT_TAPS(4'h9), .SEED(4'h1)) dut_b (
        .clk(clk), .reset(reset), .enable(en4), .load(load), .s_reg_in(s_reg_in),
        .seed_load(seed_load), .seed_in(seed_in4), .tap_load(tap_load), .tap_in(tap_in4),
        .out_ready(out_ready), .s_reg(b_s_reg), .taps(b_taps), .out_data(b_data),
        .out_valid(b_valid), .lockup(b_lockup), .period(b_period), .period_valid(b_pv)
    );

    lfsr_gen #(.N(8), .W(3)) dut_c (
        .clk(clk), .reset(reset), .enable(en8), .load(load), .s_reg_in(s_reg_in),
        .seed_load(seed_load), .seed_in(seed_in8), .tap_load(tap_load), .tap_in(tap_in8),
        .out_ready(out_ready), .s_reg(c_s_reg), .taps(c_taps), .out_data(c_data),
        .out_valid(c_valid), .lockup(c_lockup), .period(c_period), .period_valid(c_pv)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "timeout");
    end

    // Scoreboards: a word is consumed when valid && ready are seen before the edge.
    always @(negedge clk) begin
        logic [0:0] e;
        if (reset && a_valid && out_ready) begin
            checks = checks + 1;
            if (exp_a_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL word_a: got unexpected word %b, none required", a_data);
            end else begin
                e = exp_a_q.pop_front();
                if (a_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL word_a: got %b required %b", a_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (reset && b_valid && out_ready) begin
            checks = checks + 1;
            if (exp_b_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL word_b: got unexpected word %b, none required", b_data);
            end else begin
                e = exp_b_q.pop_front();
                if (b_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL word_b: got %b required %b", b_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (mon_c && reset && c_valid && out_ready) begin
            checks = checks + 1;
            if (exp_c_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL word_c: got unexpected word %b, none required", c_data);
            end else begin
                e = exp_c_q.pop_front();
                if (c_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL word_c: got %b required %b", c_data, e);
                end
            end
        end
    end

    // Reference model: one advance of w steps on an n-bit state.
    task automatic m_adv(input int n, input int w, input logic [7:0] t,
                         inout logic [7:0] st, output logic [7:0] word);
        logic [7:0] mask;
        logic       fb;
        mask = 8'((1 << n) - 1);
        word = '0;
        for (int i = 0; i < w; i++) begin
            word = {word[6:0], st[n-1]};
            fb   = ^(st & t & mask);
            st   = ((st << 1) | {7'd0, fb}) & mask;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks = checks + 8;
        if (c_s_reg !== 8'h01) begin errors++; $display("FAIL reset_s_reg: got %h required 01", c_s_reg); end
        if (c_taps !== 8'hB8) begin errors++; $display("FAIL reset_taps: got %h required b8", c_taps); end
        if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", c_valid); end
        if (c_lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b required 0", c_lockup); end
        if (c_period !== 8'h00) begin errors++; $display("FAIL reset_period: got %h required 00", c_period); end
        if (c_pv !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b required 0", c_pv); end
        if (a_s_reg !== 4'h1) begin errors++; $display("FAIL reset_s_reg_a: got %h required 1", a_s_reg); end
        if (b_taps !== 4'h9) begin errors++; $display("FAIL reset_taps_b: got %h required 9", b_taps); end
    endtask

    task automatic test_single_bit;
        logic [14:0] pat;
        logic [3:0]  b_tbl[3];
        logic [7:0]  st_a, st_b, wa, wb;
        int          pulses_a, pulses_b;
        pat = 15'b000111101011001;
        b_tbl = '{4'h7, 4'hE, 4'hA};
        seed_in4 = 4'b0001; seed_load = 1'b1; tick; seed_load = 1'b0;
        checks++;
        if (a_s_reg !== 4'h1) begin errors++; $display("FAIL seed_a: got %h required 1", a_s_reg); end
        for (int r = 0; r < 2; r++)
            for (int i = 14; i >= 0; i--) exp_a_q.push_back(pat[i]);
        st_a = 8'h01; st_b = 8'h01; pulses_a = 0; pulses_b = 0;
        en4 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_adv(4, 1, 8'h09, st_a, wa);
            m_adv(4, 2, 8'h09, st_b, wb);
            exp_b_q.push_back(wb[1:0]);
            tick;
            checks = checks + 2;
            if (a_s_reg !== st_a[3:0]) begin errors++; $display("FAIL step_a[%0d]: got %h required %h", i, a_s_reg, st_a[3:0]); end
            if (b_s_reg !== st_b[3:0]) begin errors++; $display("FAIL step_b[%0d]: got %h required %h", i, b_s_reg, st_b[3:0]); end
            if (i < 3) begin
                checks++;
                if (b_s_reg !== b_tbl[i]) begin errors++; $display("FAIL table_b[%0d]: got %h required %h", i, b_s_reg, b_tbl[i]); end
            end
            if (a_pv) begin
                pulses_a++; checks++;
                if (a_period !== 4'd15) begin errors++; $display("FAIL period_a: got %0d required 15", a_period); end
            end
            if (b_pv) begin
                pulses_b++; checks++;
                if (b_period !== 4'd15) begin errors++; $display("FAIL period_b: got %0d required 15", b_period); end
            end
        end
        en4 = 1'b0; tick; tick;
        checks = checks + 4;
        if (pulses_a != 2) begin errors++; $display("FAIL pulses_a: got %0d required 2", pulses_a); end
        if (pulses_b != 2) begin errors++; $display("FAIL pulses_b: got %0d required 2", pulses_b); end
        if (exp_a_q.size() != 0) begin errors++; $display("FAIL drain_a: got %0d left required 0", exp_a_q.size()); end
        if (exp_b_q.size() != 0) begin errors++; $display("FAIL drain_b: got %0d left required 0", exp_b_q.size()); end
    endtask

    task automatic test_backpressure;
        logic [7:0] st_a, st_b, wa, wb;
        seed_in4 = 4'b0001; seed_load = 1'b1; tick; seed_load = 1'b0;
        st_a = 8'h01; st_b = 8'h01;
        en4 = 1'b1;
        m_adv(4, 1, 8'h09, st_a, wa); exp_a_q.push_back(wa[0:0]);
        m_adv(4, 2, 8'h09, st_b, wb); exp_b_q.push_back(wb[1:0]);
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks = checks + 5;
            if (a_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_a[%0d]: got %b required 1", i, a_valid); end
            if (b_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_b[%0d]: got %b required 1", i, b_valid); end
            if (a_s_reg !== st_a[3:0]) begin errors++; $display("FAIL bp_state_a[%0d]: got %h required %h", i, a_s_reg, st_a[3:0]); end
            if (b_s_reg !== st_b[3:0]) begin errors++; $display("FAIL bp_state_b[%0d]: got %h required %h", i, b_s_reg, st_b[3:0]); end
            if (b_data !== wb[1:0]) begin errors++; $display("FAIL bp_data_b[%0d]: got %b required %b", i, b_data, wb[1:0]); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_adv(4, 1, 8'h09, st_a, wa); exp_a_q.push_back(wa[0:0]);
            m_adv(4, 2, 8'h09, st_b, wb); exp_b_q.push_back(wb[1:0]);
            tick;
            checks = checks + 2;
            if (a_s_reg !== st_a[3:0]) begin errors++; $display("FAIL resume_a[%0d]: got %h required %h", i, a_s_reg, st_a[3:0]); end
            if (b_s_reg !== st_b[3:0]) begin errors++; $display("FAIL resume_b[%0d]: got %h required %h", i, b_s_reg, st_b[3:0]); end
        end
        en4 = 1'b0; tick; tick;
        checks = checks + 2;
        if (exp_a_q.size() != 0) begin errors++; $display("FAIL bp_drain_a: got %0d left required 0", exp_a_q.size()); end
        if (exp_b_q.size() != 0) begin errors++; $display("FAIL bp_drain_b: got %0d left required 0", exp_b_q.size()); end
    endtask

    task automatic test_lockup;
        logic [7:0] st_c, wc;
        en8 = 1'b0; seed_in8 = 8'h00; seed_load = 1'b1; tick; seed_load = 1'b0;
        checks = checks + 2;
        if (c_s_reg !== 8'h00) begin errors++; $display("FAIL zero_load: got %h required 00", c_s_reg); end
        if (c_lockup !== 1'b0) begin errors++; $display("FAIL zero_lockup: got %b required 0", c_lockup); end
        en8 = 1'b1; tick;
        checks = checks + 3;
        if (c_lockup !== 1'b1) begin errors++; $display("FAIL lockup_pulse: got %b required 1", c_lockup); end
        if (c_s_reg !== 8'h01) begin errors++; $display("FAIL lockup_seed: got %h required 01", c_s_reg); end
        if (c_valid !== 1'b0) begin errors++; $display("FAIL lockup_valid: got %b required 0", c_valid); end
        st_c = 8'h01;
        for (int i = 0; i < 4; i++) begin
            m_adv(8, 3, 8'hB8, st_c, wc); exp_c_q.push_back(wc[2:0]);
            tick;
            checks = checks + 2;
            if (c_s_reg !== st_c) begin errors++; $display("FAIL post_lockup[%0d]: got %h required %h", i, c_s_reg, st_c); end
            if (c_lockup !== 1'b0) begin errors++; $display("FAIL lockup_once[%0d]: got %b required 0", i, c_lockup); end
        end
        en8 = 1'b0; tick; tick;
        checks++;
        if (exp_c_q.size() != 0) begin errors++; $display("FAIL lockup_drain: got %0d left required 0", exp_c_q.size()); end
    endtask

    task automatic test_serial_load;
        logic [7:0] pat;
        pat = 8'b1010_1010;
        en8 = 1'b0; load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_reg_in = pat[7-i];
            tick;
        end
        load = 1'b0;
        checks = checks + 3;
        if (c_s_reg !== 8'hAA) begin errors++; $display("FAIL serial_load: got %h required aa", c_s_reg); end
        if (a_s_reg !== 4'hA) begin errors++; $display("FAIL serial_load_a: got %h required a", a_s_reg); end
        if (c_valid !== 1'b0) begin errors++; $display("FAIL serial_valid: got %b required 0", c_valid); end
        en8 = 1'b1; load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_reg_in = pat[7-i];
            if (i == 7) begin seed_load = 1'b1; seed_in8 = 8'h3C; end
            tick;
        end
        load = 1'b0; seed_load = 1'b0; en8 = 1'b0;
        checks = checks + 2;
        if (c_s_reg !== 8'h3C) begin errors++; $display("FAIL seed_wins: got %h required 3c", c_s_reg); end
        if (c_valid !== 1'b0) begin errors++; $display("FAIL load_blocks_advance: got %b required 0", c_valid); end
    endtask

    task automatic test_reset_taps;
        logic [7:0] st_c, wc;
        mon_c = 1'b0;
        seed_in8 = 8'h5A; seed_load = 1'b1; tick; seed_load = 1'b0;
        tap_in8 = 8'h8E; tap_load = 1'b1; tick; tap_load = 1'b0;
        checks++;
        if (c_taps !== 8'h8E) begin errors++; $display("FAIL tap_load: got %h required 8e", c_taps); end
        en8 = 1'b1; tick; tick; tick;
        reset = 1'b0; tick; reset = 1'b1; en8 = 1'b0;
        checks = checks + 4;
        if (c_s_reg !== 8'h01) begin errors++; $display("FAIL mid_reset_s_reg: got %h required 01", c_s_reg); end
        if (c_taps !== 8'hB8) begin errors++; $display("FAIL mid_reset_taps: got %h required b8", c_taps); end
        if (c_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b required 0", c_valid); end
        if (c_period !== 8'h00) begin errors++; $display("FAIL mid_reset_period: got %h required 00", c_period); end
        st_c = 8'h01;
        m_adv(8, 3, 8'hB8, st_c, wc);
        tap_in8 = 8'hE1; tap_load = 1'b1; en8 = 1'b1; tick; tap_load = 1'b0;
        checks = checks + 3;
        if (c_s_reg !== st_c) begin errors++; $display("FAIL old_taps_state: got %h required %h", c_s_reg, st_c); end
        if (c_data !== wc[2:0]) begin errors++; $display("FAIL old_taps_word: got %b required %b", c_data, wc[2:0]); end
        if (c_taps !== 8'hE1) begin errors++; $display("FAIL new_taps: got %h required e1", c_taps); end
        m_adv(8, 3, 8'hE1, st_c, wc);
        tick;
        checks = checks + 2;
        if (c_s_reg !== st_c) begin errors++; $display("FAIL new_taps_state: got %h required %h", c_s_reg, st_c); end
        if (c_data !== wc[2:0]) begin errors++; $display("FAIL new_taps_word: got %b required %b", c_data, wc[2:0]); end
        en8 = 1'b0; tick; tick;
        mon_c = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; en4 = 1'b0; en8 = 1'b0; load = 1'b0; s_reg_in = 1'b0;
        seed_load = 1'b0; tap_load = 1'b0; out_ready = 1'b1; mon_c = 1'b1;
        seed_in4 = 4'h1; tap_in4 = 4'h9; seed_in8 = 8'h01; tap_in8 = 8'hB8;
        tick; tick;
        test_reset;
        reset = 1'b1;
        tick;
        test_single_bit;
        test_backpressure;
        test_lockup;
        test_serial_load;
        test_reset_taps;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
